// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SPI-mode SD card responder.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_NCR,
        S_RESP,
        S_NAC,
        S_TOKEN,
        S_DATA,
        S_CRC
    } state_t;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam logic [7:0] R1_READY   = 8'h00;
    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;

    localparam logic [7:0]  FILL_BYTE  = 8'hFF;
    localparam logic [7:0]  DATA_TOKEN = 8'hFE;
    // CCS=1: block addressing, so CMD17 arguments are block numbers
    localparam logic [31:0] OCR        = 32'hC0FF_8000;
    localparam int          BLOCK_BYTES = 512;

    // R1 status: error flags plus the in-idle bit
    function automatic logic [7:0] r1_status(input logic [7:0] flags, input logic idle);
        return flags | {7'b0, idle};
    endfunction

endpackage

// File: rtl/sd_spi_byte_shifter.sv
// SPI mode-0 byte shifter: input synchronizers, SCLK edge detect, rx byte
// assembly and tx byte serialisation. Carries no protocol knowledge.
module sd_spi_byte_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       sd_clk,
    input  logic       sd_cs_n,
    input  logic       sd_mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       sd_miso,
    output logic       cs_active,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   clk_q;
    logic                   clk_s;
    logic                   mosi_s;
    logic                   rise;
    logic                   fall;
    logic [6:0]             rx_sr;
    logic [2:0]             bit_cnt;
    logic [7:0]             tx_sr;

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_active = ~cs_sync[SYNC_STAGES-1];
    assign rise      = clk_s & ~clk_q;
    assign fall      = ~clk_s & clk_q;
    assign byte_done = cs_active & rise & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr, mosi_s};

    // Bring the host pins into the Clk domain and keep last SCLK for edge detect
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '1;
            clk_q     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], sd_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], sd_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], sd_mosi};
            clk_q     <= clk_s;
        end
    end

    // Sample MOSI on each rising edge; the bit counter wraps every byte
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else if (!cs_active) begin
            bit_cnt <= '0;
        end else if (rise) begin
            rx_sr   <= {rx_sr[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Shift MISO out on falling edges; a load lands between the 8th rise and
    // the next fall because Clk is at least 8x SCLK
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tx_sr   <= 8'hFF;
            sd_miso <= 1'b1;
        end else if (!cs_active) begin
            tx_sr   <= 8'hFF;
            sd_miso <= 1'b1;
        end else if (tx_load) begin
            tx_sr <= tx_data;
        end else if (fall) begin
            sd_miso <= tx_sr[7];
            tx_sr   <= {tx_sr[6:0], 1'b1};
        end
    end

endmodule

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card responder: command decode, R1/R3/R7 responses and
// CMD17 single-block reads served from a byte-wide memory port.
//
// state   | meaning
// S_IDLE  | waiting for a byte with bits[7:6]=01 (command start)
// S_CMD   | collecting argument and CRC bytes
// S_NCR   | sending 0xFF filler before the response
// S_RESP  | sending R1 and any trailing R3/R7 bytes
// S_NAC   | sending 0xFF filler before the data token
// S_TOKEN | sending the 0xFE start-block token
// S_DATA  | sending the 512 block bytes
// S_CRC   | sending two fixed 0xFF CRC bytes
module sd_spi_card_responder
    import sd_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NCR_BYTES   = 1,   // must be >= 1
    parameter int NAC_BYTES   = 2,   // must be >= 1
    parameter int INIT_POLLS  = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              sd_clk,
    input  logic              sd_cs_n,
    input  logic              sd_mosi,
    output logic              sd_miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_strobe,
    output logic [5:0]        cmd_index
);

    localparam logic [9:0] NCR_LAST   = 10'(NCR_BYTES - 1);
    localparam logic [9:0] NAC_LAST   = 10'(NAC_BYTES - 1);
    localparam logic [9:0] DATA_LAST  = 10'(BLOCK_BYTES - 1);
    localparam logic [7:0] POLL_LIMIT = 8'(INIT_POLLS);

    logic       cs_active;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic       tx_load;
    logic [7:0] tx_data;

    state_t      state;
    logic [9:0]  cnt;
    logic [5:0]  cmd_idx_r;
    logic [31:0] arg;
    logic [7:0]  r1_r;
    logic [31:0] trail_sr;
    logic [2:0]  trail_cnt;
    logic        data_phase;
    logic        idle_flag;
    logic        app_flag;
    logic [7:0]  poll_cnt;
    logic        rd_pending;
    logic [7:0]  hold;

    sd_spi_byte_shifter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_shifter (
        .Clk       (Clk),
        .Reset     (Reset),
        .sd_clk    (sd_clk),
        .sd_cs_n   (sd_cs_n),
        .sd_mosi   (sd_mosi),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .sd_miso   (sd_miso),
        .cs_active (cs_active),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    // Protocol FSM, card state and block-data prefetch; every byte completion
    // loads the next tx byte (0xFF unless the state has something to say)
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            cmd_idx_r  <= '0;
            arg        <= '0;
            r1_r       <= FILL_BYTE;
            trail_sr   <= '1;
            trail_cnt  <= '0;
            data_phase <= 1'b0;
            idle_flag  <= 1'b1;
            app_flag   <= 1'b0;
            poll_cnt   <= '0;
            cmd_strobe <= 1'b0;
            cmd_index  <= '0;
            tx_load    <= 1'b0;
            tx_data    <= FILL_BYTE;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            rd_pending <= 1'b0;
            hold       <= '0;
        end else begin
            tx_load    <= 1'b0;
            cmd_strobe <= 1'b0;
            mem_rd     <= 1'b0;
            rd_pending <= mem_rd;
            if (rd_pending) begin
                hold     <= mem_rdata;
                mem_addr <= mem_addr + ADDR_W'(1);
            end

            if (!cs_active) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else if (byte_done) begin
                tx_load <= 1'b1;
                tx_data <= FILL_BYTE;
                case (state)
                    S_IDLE: begin
                        if (rx_byte[7:6] == 2'b01) begin
                            state     <= S_CMD;
                            busy      <= 1'b1;
                            cmd_idx_r <= rx_byte[5:0];
                            cnt       <= '0;
                        end
                    end
                    S_CMD: begin
                        if (cnt == 10'd4) begin
                            // CRC byte: frame complete, decode it
                            cmd_strobe <= 1'b1;
                            cmd_index  <= cmd_idx_r;
                            app_flag   <= (cmd_idx_r == CMD55);
                            trail_sr   <= '1;
                            trail_cnt  <= '0;
                            data_phase <= 1'b0;
                            r1_r       <= r1_status(R1_ILLEGAL, idle_flag);
                            case (cmd_idx_r)
                                CMD0: begin
                                    idle_flag <= 1'b1;
                                    r1_r      <= R1_IDLE;
                                end
                                CMD8: begin
                                    r1_r      <= r1_status(R1_READY, idle_flag);
                                    trail_sr  <= {8'h00, 8'h00, 8'h01, arg[7:0]};
                                    trail_cnt <= 3'd4;
                                end
                                CMD55: r1_r <= r1_status(R1_READY, idle_flag);
                                CMD41: begin
                                    if (app_flag) begin
                                        if (poll_cnt < POLL_LIMIT) begin
                                            poll_cnt <= poll_cnt + 8'd1;
                                            r1_r     <= R1_IDLE;
                                        end else begin
                                            idle_flag <= 1'b0;
                                            r1_r      <= R1_READY;
                                        end
                                    end
                                end
                                CMD58: begin
                                    r1_r      <= r1_status(R1_READY, idle_flag);
                                    trail_sr  <= OCR;
                                    trail_cnt <= 3'd4;
                                end
                                CMD17: begin
                                    if (idle_flag) begin
                                        r1_r <= r1_status(R1_ILLEGAL, 1'b1);
                                    end else begin
                                        r1_r       <= R1_READY;
                                        data_phase <= 1'b1;
                                        mem_addr   <= ADDR_W'({arg, 9'b0});
                                    end
                                end
                                default: ;
                            endcase
                            state <= S_NCR;
                            cnt   <= '0;
                        end else begin
                            arg <= {arg[23:0], rx_byte};
                            cnt <= cnt + 10'd1;
                        end
                    end
                    S_NCR: begin
                        if (cnt == NCR_LAST) begin
                            tx_data <= r1_r;
                            state   <= S_RESP;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    S_RESP: begin
                        if (trail_cnt != 3'd0) begin
                            tx_data   <= trail_sr[31:24];
                            trail_sr  <= {trail_sr[23:0], 8'hFF};
                            trail_cnt <= trail_cnt - 3'd1;
                        end else if (data_phase) begin
                            state <= S_NAC;
                            cnt   <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    S_NAC: begin
                        if (cnt == NAC_LAST) begin
                            tx_data <= DATA_TOKEN;
                            mem_rd  <= 1'b1;
                            state   <= S_TOKEN;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    S_TOKEN: begin
                        tx_data <= hold;
                        mem_rd  <= 1'b1;
                        state   <= S_DATA;
                        cnt     <= '0;
                    end
                    S_DATA: begin
                        if (cnt == DATA_LAST) begin
                            state <= S_CRC;
                            cnt   <= '0;
                        end else begin
                            // loading byte cnt+1; prefetch cnt+2 while it exists
                            tx_data <= hold;
                            mem_rd  <= (cnt < DATA_LAST - 10'd1);
                            cnt     <= cnt + 10'd1;
                        end
                    end
                    S_CRC: begin
                        if (cnt == 10'd1) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Self-checking bench for sd_spi_card_responder: drives SPI mode-0 frames and
// compares every MISO byte against a command-level card model.
module tb_sd_spi_card_responder;

    localparam int SYNC_STAGES = 2;
    localparam int NCR_BYTES   = 1;
    localparam int NAC_BYTES   = 2;
    localparam int INIT_POLLS  = 1;
    localparam int ADDR_W      = 32;
    localparam int HALF        = 4;     // sd_clk half period in Clk cycles

    logic              Clk = 1'b0;
    logic              Reset;
    logic              sd_clk;
    logic              sd_cs_n;
    logic              sd_mosi;
    logic              sd_miso;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata = 8'h00;
    logic              busy;
    logic              cmd_strobe;
    logic [5:0]        cmd_index;

    always #5 Clk = ~Clk;

    sd_spi_card_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .NCR_BYTES  (NCR_BYTES),
        .NAC_BYTES  (NAC_BYTES),
        .INIT_POLLS (INIT_POLLS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .sd_clk     (sd_clk),
        .sd_cs_n    (sd_cs_n),
        .sd_mosi    (sd_mosi),
        .sd_miso    (sd_miso),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .cmd_strobe (cmd_strobe),
        .cmd_index  (cmd_index)
    );

    logic [7:0] mem [0:4095];

    always @(posedge Clk) if (mem_rd) mem_rdata <= mem[mem_addr[11:0]];

    int n_strobe = 0;
    int n_rd     = 0;
    always @(posedge Clk) begin
        if (cmd_strobe) n_strobe++;
        if (mem_rd)     n_rd++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // card model: flags plus the expected MISO byte stream after a command
    bit         m_idle = 1'b1;
    bit         m_app  = 1'b0;
    int         m_poll = 0;
    logic [7:0] exp_q[$];
    int         exp_rd;
    int         s0, r0;

    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [7:0] st;
        int base;
        exp_q.delete();
        exp_rd = 0;
        st = m_idle ? 8'h01 : 8'h00;
        repeat (NCR_BYTES) exp_q.push_back(8'hFF);
        case (idx)
            6'd0: begin m_idle = 1'b1; exp_q.push_back(8'h01); end
            6'd8: begin
                exp_q.push_back(st); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
                exp_q.push_back(8'h01); exp_q.push_back(arg[7:0]);
            end
            6'd55: exp_q.push_back(st);
            6'd41: begin
                if (!m_app) exp_q.push_back(st | 8'h04);
                else if (m_poll < INIT_POLLS) begin m_poll++; exp_q.push_back(8'h01); end
                else begin m_idle = 1'b0; exp_q.push_back(8'h00); end
            end
            6'd58: begin
                exp_q.push_back(st); exp_q.push_back(8'hC0); exp_q.push_back(8'hFF);
                exp_q.push_back(8'h80); exp_q.push_back(8'h00);
            end
            6'd17: begin
                if (m_idle) exp_q.push_back(8'h05);
                else begin
                    exp_q.push_back(8'h00);
                    repeat (NAC_BYTES) exp_q.push_back(8'hFF);
                    exp_q.push_back(8'hFE);
                    base = int'(arg[2:0]) * 512;
                    for (int i = 0; i < 512; i++) exp_q.push_back(mem[base + i]);
                    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
                    exp_rd = 512;
                end
            end
            default: exp_q.push_back(st | 8'h04);
        endcase
        m_app = (idx == 6'd55);
    endtask

    // one SPI byte, called at a negedge of Clk; returns with sd_clk high
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int b = 7; b >= 0; b--) begin
            sd_clk  = 1'b0;
            sd_mosi = tx[b];
            repeat (HALF) @(negedge Clk);
            rx[b]  = sd_miso;
            sd_clk = 1'b1;
            repeat (HALF) @(negedge Clk);
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] frame [6];
        logic [7:0] rx;
        model_cmd(idx, arg);
        s0 = n_strobe;
        r0 = n_rd;
        frame[0] = {2'b01, idx};
        frame[1] = arg[31:24];
        frame[2] = arg[23:16];
        frame[3] = arg[15:8];
        frame[4] = arg[7:0];
        frame[5] = crc;
        for (int i = 0; i < 6; i++) begin
            spi_byte(frame[i], rx);
            check("cmd_miso", 32'(rx), 32'hFF);
        end
        check("busy_mid", 32'(busy), 32'd1);
    endtask

    task automatic read_resp(input int n);
        logic [7:0] rx;
        for (int i = 0; i < n; i++) begin
            spi_byte(8'hFF, rx);
            check("resp_byte", 32'(rx), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        send_cmd(idx, arg, crc);
        read_resp(exp_q.size());
        check("strobe_cnt", 32'(n_strobe - s0), 32'd1);
        check("cmd_index", 32'(cmd_index), 32'(idx));
        check("rd_cnt", 32'(n_rd - r0), 32'(exp_rd));
        check("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(sd_miso), 32'd1);
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_strobe"}, 32'(cmd_strobe), 32'd0);
        check({tag, "_index"}, 32'(cmd_index), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rx, junk;
        logic [5:0]  pool [8];
        logic [5:0]  idx;
        int          snap;
        pool = '{6'd0, 6'd8, 6'd9, 6'd13, 6'd17, 6'd41, 6'd55, 6'd58};
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        Reset = 1'b1; sd_clk = 1'b0; sd_cs_n = 1'b1; sd_mosi = 1'b1;
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        check_reset_outputs("rst");
        sd_cs_n = 1'b0;
        repeat (4) @(negedge Clk);

        // before init: CMD17 rejected while idle
        run_cmd(6'd17, 32'd0, 8'hFF);
        run_cmd(6'd0, 32'd0, 8'h95);
        run_cmd(6'd8, 32'h0000_01AA, 8'h87);
        run_cmd(6'd55, 32'd0, 8'hFF);
        run_cmd(6'd41, 32'h4000_0000, 8'hFF);
        run_cmd(6'd55, 32'd0, 8'hFF);
        run_cmd(6'd41, 32'h4000_0000, 8'hFF);
        run_cmd(6'd58, 32'd0, 8'hFF);
        run_cmd(6'd9, 32'd0, 8'hFF);

        // full block read from 0x600
        run_cmd(6'd17, 32'd3, 8'hFF);

        // abort after 100 data bytes
        send_cmd(6'd17, 32'd5, 8'hFF);
        read_resp(NCR_BYTES + 1 + NAC_BYTES + 1 + 100);
        exp_q.delete();
        check("abort_rd", 32'(n_rd - r0), 32'd102);
        sd_clk = 1'b0;
        sd_cs_n = 1'b1;
        repeat (SYNC_STAGES + 2) @(posedge Clk);
        @(negedge Clk);
        check("abort_miso", 32'(sd_miso), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        snap = n_rd;
        repeat (100) @(negedge Clk);
        check("abort_no_rd", 32'(n_rd), 32'(snap));
        sd_cs_n = 1'b0;
        repeat (4) @(negedge Clk);
        run_cmd(6'd17, 32'd0, 8'hFF);

        // Reset in the middle of a block
        send_cmd(6'd17, 32'd1, 8'hFF);
        read_resp(NCR_BYTES + 1 + NAC_BYTES + 1 + 10);
        exp_q.delete();
        Reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        m_idle = 1'b1; m_app = 1'b0; m_poll = 0;
        @(negedge Clk);
        sd_cs_n = 1'b1; sd_clk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        sd_cs_n = 1'b0;
        repeat (4) @(negedge Clk);
        run_cmd(6'd17, 32'd0, 8'hFF);

        // random command mix with junk idle bytes in between
        for (int n = 0; n < 8; n++) begin
            junk = 8'($urandom);
            if (junk[7:6] == 2'b01) junk[7] = 1'b1;
            snap = n_strobe;
            spi_byte(junk, rx);
            check("junk_miso", 32'(rx), 32'hFF);
            check("junk_ignored", 32'(n_strobe), 32'(snap));
            idx = pool[$urandom_range(7, 0)];
            if (idx == 6'd17 && !m_idle) idx = 6'd58;
            run_cmd(idx, $urandom, 8'hFF);
        end

        sd_clk = 1'b0;
        sd_cs_n = 1'b1;
        repeat (5) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
